// File: rtl/check_state_pkg.sv
// Shared constants and state type for the sequence-check block.
// The memory game compares 2-bit elements over a growing round window.
package check_state_pkg;

    localparam int SEQ_W     = 32;
    localparam int ROUND_W   = 4;
    localparam int ELEM_W    = 2;
    localparam int MAX_ROUND = 15;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RESULT = 1'b1
    } state_t;

endpackage

// File: rtl/check_state_seq_mask_cmp.sv
// Combinational compare of two packed sequences over elements 0..round.
// Elements above the current round are masked out and never affect match.
module seq_mask_cmp #(
    parameter int SEQ_W   = 32,
    parameter int ROUND_W = 4,
    parameter int ELEM_W  = 2
) (
    input  logic [SEQ_W-1:0]   seq_a,
    input  logic [SEQ_W-1:0]   seq_b,
    input  logic [ROUND_W-1:0] round,
    output logic               match
);

    localparam int NUM_ELEM = SEQ_W / ELEM_W;

    logic [SEQ_W-1:0] mask;

    generate
        for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_mask
            // Element gi participates once the round has reached it.
            assign mask[gi*ELEM_W +: ELEM_W] = {ELEM_W{(32'(round) >= gi)}};
        end
    endgenerate

    assign match = (((seq_a ^ seq_b) & mask) == '0);

endmodule

// File: rtl/check_state.sv
// Registered round checker: compares the player's sequence with memory on
// each en_check edge and advances, saturates or clears the round counter.
module check_state #(
    parameter int SEQ_W   = 32,
    parameter int ROUND_W = 4,
    parameter int ELEM_W  = 2
) (
    input  logic               clk,
    input  logic               rst_check,
    input  logic               en_check,
    input  logic [SEQ_W-1:0]   seq_in_check,
    input  logic [SEQ_W-1:0]   seq_mem,
    input  logic [ROUND_W-1:0] round_ctr_in,
    output logic [ROUND_W-1:0] round_ctr_out,
    output logic               complete_check,
    output logic               game_complete
);

    import check_state_pkg::*;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUND);

    state_t             state_reg, state_next;
    logic [ROUND_W-1:0] round_reg, round_next;
    logic               complete_reg, complete_next;
    logic               game_reg, game_next;
    logic               match;

    seq_mask_cmp #(
        .SEQ_W   (SEQ_W),
        .ROUND_W (ROUND_W),
        .ELEM_W  (ELEM_W)
    ) u_cmp (
        .seq_a (seq_in_check),
        .seq_b (seq_mem),
        .round (round_ctr_in),
        .match (match)
    );

    always_ff @(posedge clk or negedge rst_check) begin
        if (!rst_check) begin
            state_reg    <= ST_IDLE;
            round_reg    <= '0;
            complete_reg <= 1'b0;
            game_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            round_reg    <= round_next;
            complete_reg <= complete_next;
            game_reg     <= game_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        round_next    = round_reg;
        complete_next = complete_reg;
        game_next     = game_reg;
        // Every enabled edge is a fresh evaluation, whether in IDLE or RESULT.
        if (en_check) begin
            state_next = ST_RESULT;
            if (!match) begin
                round_next    = '0;
                complete_next = 1'b0;
                game_next     = 1'b0;
            end else if (round_ctr_in >= LAST_ROUND) begin
                round_next    = LAST_ROUND;
                complete_next = 1'b1;
                game_next     = 1'b1;
            end else begin
                round_next    = round_ctr_in + 1'b1;
                complete_next = 1'b1;
            end
        end
    end

    assign round_ctr_out  = round_reg;
    assign complete_check = complete_reg;
    assign game_complete  = game_reg;

endmodule

// File: tb/tb_check_state.sv
// Randomized and directed bench for check_state against an element-wise
// reference model of the round-check rules.
module tb_check_state;

    logic        clk = 1'b0;
    logic        rst_check;
    logic        en_check;
    logic [31:0] seq_in_check;
    logic [31:0] seq_mem;
    logic [3:0]  round_ctr_in;
    logic [3:0]  round_ctr_out;
    logic        complete_check;
    logic        game_complete;

    int n_tests = 0;
    int n_fail  = 0;

    int m_round;
    int m_comp;
    int m_game;

    always #5 clk = ~clk;

    check_state dut (
        .clk            (clk),
        .rst_check      (rst_check),
        .en_check       (en_check),
        .seq_in_check   (seq_in_check),
        .seq_mem        (seq_mem),
        .round_ctr_in   (round_ctr_in),
        .round_ctr_out  (round_ctr_out),
        .complete_check (complete_check),
        .game_complete  (game_complete)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit ref_match(input int r, input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k <= r; k++)
            if (((a >> (2 * k)) & 32'd3) != ((b >> (2 * k)) & 32'd3)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_round"}, int'(round_ctr_out), m_round);
        check_eq({tag, "_comp"}, int'(complete_check), m_comp);
        check_eq({tag, "_game"}, int'(game_complete), m_game);
        $display("[TB] %s en=%0b r=%0d in=%h mem=%h -> round=%0d comp=%0b game=%0b",
                 tag, en_check, round_ctr_in, seq_in_check, seq_mem,
                 round_ctr_out, complete_check, game_complete);
    endtask

    // Called at a falling edge: drive, advance one cycle, check at next falling edge.
    task automatic apply(input string tag, input bit en, input int r,
                         input logic [31:0] a, input logic [31:0] b);
        en_check     = en;
        round_ctr_in = 4'(r);
        seq_in_check = a;
        seq_mem      = b;
        if (en) begin
            if (!ref_match(r, a, b)) begin
                m_round = 0; m_comp = 0; m_game = 0;
            end else if (r == 15) begin
                m_round = 15; m_comp = 1; m_game = 1;
            end else begin
                m_round = r + 1; m_comp = 1;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic model_reset();
        m_round = 0; m_comp = 0; m_game = 0;
    endtask

    initial begin
        logic [31:0] a, b;
        int r;
        model_reset();
        rst_check    = 1'b0;
        en_check     = 1'b0;
        seq_in_check = '0;
        seq_mem      = '0;
        round_ctr_in = '0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_check = 1'b1;
        for (int i = 0; i < 3; i++) apply("idle", 1'b0, 5, 32'h1234_5678, 32'h0);

        apply("pass_r0", 1'b1, 0, 32'h0ABC_DEF0, 32'h0ABC_DEF0);
        check_eq("pass_r0_const", int'(round_ctr_out), 1);
        apply("fail_r1", 1'b1, 1, 32'hDEAD_BEEF, 32'h0ABC_DEF0);
        check_eq("fail_r1_const", int'(complete_check), 0);
        apply("final_r15", 1'b1, 15, 32'h0ABC_DEF0, 32'h0ABC_DEF0);
        check_eq("final_const", int'(game_complete), 1);
        apply("final_again", 1'b1, 15, 32'h0ABC_DEF0, 32'h0ABC_DEF0);
        check_eq("sat_const", int'(round_ctr_out), 15);
        apply("mask_r1", 1'b1, 1, 32'hFFFF_000F, 32'h0000_000F);
        check_eq("mask_r1_const", int'(round_ctr_out), 2);
        apply("mask_r15", 1'b1, 15, 32'hFFFF_000F, 32'h0000_000F);
        check_eq("mask_r15_const", int'(complete_check), 0);

        // Hold: pass, then wiggle inputs with en_check low.
        apply("hold_pass", 1'b1, 15, 32'h5555_AAAA, 32'h5555_AAAA);
        for (int i = 0; i < 5; i++)
            apply("hold", 1'b0, int'($urandom_range(0, 15)), $urandom, $urandom);

        // Asynchronous reset away from any clock edge.
        @(posedge clk);
        #2 rst_check = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst_check = 1'b1;
        apply("post_rst", 1'b1, 3, 32'h0000_00E4, 32'h0000_00E4);

        for (int i = 0; i < 300; i++) begin
            b = $urandom;
            a = b;
            r = int'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) a = a ^ (32'd1 << $urandom_range(0, 31));
            apply("rand", ($urandom_range(0, 9) < 7), r, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/check_state.md
CHECK_STATE -- requirements
Module: check_state

Interface
REQ-001 Parameter SEQ_W, default 32: width of the player and memory sequence buses.
REQ-002 Parameter ROUND_W, default 4: width of the round counters.
REQ-003 Parameter ELEM_W, default 2: bits per sequence element, so SEQ_W/ELEM_W = 16 elements.
REQ-004 Signal clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Signal rst_check, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Signal en_check, input, 1 bit: check request, sampled on each rising clk edge.
REQ-007 Signal seq_in_check, input, SEQ_W bits: sequence entered by the player; element k occupies bits [2k+1:2k].
REQ-008 Signal seq_mem, input, SEQ_W bits: reference sequence from memory, same element packing.
REQ-009 Signal round_ctr_in, input, ROUND_W bits: current round r, 0..15; round r covers elements 0..r.
REQ-010 Signal round_ctr_out, output, ROUND_W bits: next round number.
REQ-011 Signal complete_check, output, 1 bit: last check passed.
REQ-012 Signal game_complete, output, 1 bit: final round (15) passed.

Function
REQ-013 The block SHALL form a compare mask with the low 2*(r+1) bits set; for r = 15 the mask SHALL be all 32 bits.
REQ-014 Match SHALL be true when ((seq_in_check XOR seq_mem) AND mask) equals zero; bits above the mask SHALL be ignored.
REQ-015 All outputs SHALL be registered, with 1-cycle latency: they update on the rising edge that samples en_check = 1 and are valid immediately after that edge.
REQ-016 On a match with r < 15: complete_check = 1, round_ctr_out = r+1, game_complete unchanged.
REQ-017 On a match with r = 15: complete_check = 1, game_complete = 1, round_ctr_out = 15 (saturate, no wrap to 0).
REQ-018 On a mismatch: complete_check = 0, round_ctr_out = 0, game_complete = 0.
REQ-019 When en_check = 0, all outputs SHALL hold their values, and input changes SHALL have no effect on them.
REQ-020 If en_check is held high for consecutive cycles, each cycle SHALL be a fresh evaluation using the inputs present at that edge.
REQ-021 Once set, game_complete SHALL remain 1 until reset or a mismatching check.
REQ-022 The block SHALL be a two-state machine: IDLE (waiting) and RESULT (holding the outcome); en_check = 1 enters or re-enters RESULT, and only reset returns to IDLE.

Reset
REQ-023 When rst_check = 0, the block SHALL immediately, regardless of clk: set round_ctr_out = 0, complete_check = 0, game_complete = 0 and state = IDLE.
REQ-024 If reset is asserted mid-operation, any pending check SHALL be discarded.
REQ-025 On deassertion, the first edge with en_check = 1 SHALL evaluate normally.

Structure
REQ-026 A shared package check_state_pkg SHALL hold SEQ_W, ROUND_W, ELEM_W, MAX_ROUND = 15 and the state enumeration type.
REQ-027 Mask generation and comparison SHALL be placed in one combinational sub-module, seq_mask_cmp (inputs: two sequences and the round; output: match).

Verification
REQ-028 Reset scenario: assert reset -> all outputs 0; release, wait 3 cycles with en_check = 0 -> outputs stay 0.
REQ-029 Pass scenario: r = 0, seq_in_check = seq_mem = 0x0ABCDEF0, one-cycle en_check pulse -> next cycle complete_check = 1, round_ctr_out = 1, game_complete = 0.
REQ-030 Fail scenario: r = 1, seq_in_check = 0xDEADBEEF, seq_mem = 0x0ABCDEF0, pulse -> complete_check = 0, round_ctr_out = 0.
REQ-031 Final-round scenario: r = 15, equal sequences 0x0ABCDEF0, pulse -> complete_check = 1, game_complete = 1, round_ctr_out = 15.
REQ-032 Masking scenario: r = 1, seq_mem = 0x0000000F, seq_in_check = 0xFFFF000F -> pass, round_ctr_out = 2. Same inputs with r = 15 -> fail.
REQ-033 Hold scenario: after a pass, change the inputs with en_check = 0 for 5 cycles -> outputs unchanged. Then assert reset mid-hold -> all outputs 0 asynchronously.
